// File: rtl/boot_overlay_if.sv
// 68000-style uds/lds/rw bus bundle. The same shape serves the CPU side
// (overlay is the slave) and the downstream memory side (overlay is the master).
interface boot_overlay_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;
    logic [ADDR_W-1:0] addr;
    logic              uds;
    logic              lds;
    logic              rw;
    logic              ack;

    modport master (
        output data_write, addr, uds, lds, rw,
        input  data_read, ack
    );

    modport slave (
        input  data_write, addr, uds, lds, rw,
        output data_read, ack
    );
endinterface

// File: rtl/boot_overlay.sv
// Boot overlay: after reset, reads inside the low window are served from a
// programmable boot ROM; everything else passes through to memory. A magic
// write to EXIT_ADDR arms exit, the following strobe negation leaves boot
// mode, and boot_req brings it back between bus cycles.
module boot_overlay #(
    parameter int              ADDR_W       = 24,
    parameter int              DATA_W       = 16,   // two byte lanes only
    parameter int              BOOT_WORDS   = 16,   // power of two, 2..4096
    parameter int              WINDOW_BYTES = 4096, // >= 2*BOOT_WORDS
    parameter int              EXIT_ADDR    = 0,
    parameter logic [DATA_W-1:0] EXIT_MAGIC = 16'hA9A9,
    parameter int              ROM_WAIT     = 1     // 0..7
) (
    input  logic                          clk,
    input  logic                          reset,
    boot_overlay_if.slave                 cpu,
    boot_overlay_if.master                mem,
    input  logic                          rom_we,
    input  logic [$clog2(BOOT_WORDS)-1:0] rom_waddr,
    input  logic [DATA_W-1:0]             rom_wdata,
    input  logic                          boot_req,
    output logic                          bootmode
);
    localparam int                IDX_W   = $clog2(BOOT_WORDS);
    localparam logic [ADDR_W:0]   WIN_LIM = (ADDR_W+1)'(WINDOW_BYTES);
    localparam logic [ADDR_W-1:0] EXIT_A  = ADDR_W'(EXIT_ADDR);
    localparam logic [2:0]        WAIT_LD = 3'(ROM_WAIT);

    typedef enum logic [1:0] {B_IDLE, B_ROM_WAIT, B_ROM_ACK, B_MEM} bus_t;
    typedef enum logic [1:0] {M_BOOT, M_ARMED, M_RUN} mode_t;

    bus_t  bus_q, bus_nxt;
    mode_t mode_q, mode_nxt;
    logic  pend_q, pend_nxt;
    logic [2:0] cnt_q, cnt_nxt;
    logic  ack_q;
    logic [DATA_W-1:0] rd_q;
    logic  prev_uds, prev_lds;

    logic [DATA_W-1:0] rom [BOOT_WORDS];

    logic             stb, start, negation, in_win, rom_hit, arm;
    logic [IDX_W-1:0] rom_idx;

    assign stb      = cpu.uds | cpu.lds;
    assign start    = stb & ~(prev_uds | prev_lds);
    // Full-word strobe release only: byte-lane drops do not complete the exit.
    assign negation = prev_uds & prev_lds & ~cpu.uds & ~cpu.lds;
    assign in_win   = {1'b0, cpu.addr} < WIN_LIM;
    assign bootmode = (mode_q != M_RUN);
    assign rom_hit  = bootmode & cpu.rw & in_win;
    // Index aliases: every BOOT_WORDS*2 bytes of the window repeat the ROM.
    assign rom_idx  = cpu.addr[IDX_W:1];
    assign arm      = (bus_q == B_IDLE) & start & ~cpu.rw & cpu.uds & cpu.lds &
                      (cpu.addr == EXIT_A) & (cpu.data_write == EXIT_MAGIC);

    // Boot ROM write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (rom_we)
            rom[rom_waddr] <= rom_wdata;
    end

    // Bus FSM next state: source is chosen once at cycle start and held.
    always_comb begin
        bus_nxt = bus_q;
        cnt_nxt = cnt_q;
        case (bus_q)
            B_IDLE: begin
                if (start) begin
                    if (rom_hit) begin
                        bus_nxt = B_ROM_WAIT;
                        cnt_nxt = WAIT_LD;
                    end else begin
                        bus_nxt = B_MEM;
                    end
                end
            end
            B_ROM_WAIT: begin
                if (cnt_q == 3'd0) bus_nxt = B_ROM_ACK;
                else               cnt_nxt = cnt_q - 3'd1;
            end
            B_ROM_ACK: if (!stb) bus_nxt = B_IDLE;
            B_MEM:     if (!stb) bus_nxt = B_IDLE;
            default:   bus_nxt = B_IDLE;
        endcase
    end

    // Bus state, registered ack and ROM data latched at cycle start so a
    // concurrent rom_we to the same word cannot change an in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q    <= B_IDLE;
            cnt_q    <= 3'd0;
            ack_q    <= 1'b0;
            rd_q     <= '0;
            prev_uds <= 1'b0;
            prev_lds <= 1'b0;
        end else begin
            bus_q    <= bus_nxt;
            cnt_q    <= cnt_nxt;
            ack_q    <= (bus_nxt == B_ROM_ACK);
            prev_uds <= cpu.uds;
            prev_lds <= cpu.lds;
            if (bus_q == B_IDLE && start && rom_hit)
                rd_q <= rom[rom_idx];
        end
    end

    // Mode FSM next state: boot_req beats arm/exit; re-entry from RUN waits
    // for the bus to go idle so a cycle never changes source mid-flight.
    always_comb begin
        mode_nxt = mode_q;
        pend_nxt = pend_q;
        case (mode_q)
            M_BOOT: begin
                pend_nxt = 1'b0;
                if (!boot_req && arm) mode_nxt = M_ARMED;
            end
            M_ARMED: begin
                pend_nxt = 1'b0;
                if (boot_req)      mode_nxt = M_BOOT;
                else if (negation) mode_nxt = M_RUN;
            end
            M_RUN: begin
                if (boot_req || pend_q) begin
                    if (bus_nxt == B_IDLE) begin
                        mode_nxt = M_BOOT;
                        pend_nxt = 1'b0;
                    end else begin
                        pend_nxt = 1'b1;
                    end
                end
            end
            default: begin
                mode_nxt = M_BOOT;
                pend_nxt = 1'b0;
            end
        endcase
    end

    // Mode state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= M_BOOT;
            pend_q <= 1'b0;
        end else begin
            mode_q <= mode_nxt;
            pend_q <= pend_nxt;
        end
    end

    // Downstream side: transparent only while a memory cycle is in flight.
    always_comb begin
        mem.addr       = cpu.addr;
        mem.data_write = cpu.data_write;
        mem.uds        = 1'b0;
        mem.lds        = 1'b0;
        mem.rw         = 1'b1;
        cpu.ack        = ack_q;
        cpu.data_read  = rd_q;
        if (bus_q == B_MEM) begin
            mem.uds       = cpu.uds;
            mem.lds       = cpu.lds;
            mem.rw        = cpu.rw;
            cpu.ack       = mem.ack;
            cpu.data_read = mem.data_read;
        end
    end
endmodule

// File: doc/boot_overlay.md
Name: boot_overlay

Overview:
- Parametrised successor to the fixed-table boot device on the 68000-style uds/lds/rw bus, with registered acknowledge.
- After reset, reads inside a configurable boot window return words from an internal programmable boot ROM. All other accesses, and all writes, go to downstream memory.
- A magic-word write arms exit. Boot mode ends at the next strobe negation. An external request re-enters boot mode.

Parameters:
- ADDR_W, 24, bus address width.
- DATA_W, 16, bus data width; must be 16 (two byte lanes).
- BOOT_WORDS, 16, boot ROM depth in words; power of two, 2..4096.
- WINDOW_BYTES, 4096, size of the overlay window starting at address 0; must be ≥ 2*BOOT_WORDS.
- EXIT_ADDR, 0, byte address of the exit-command register.
- EXIT_MAGIC, 16'hA9A9, exit-command data word.
- ROM_WAIT, 1, wait cycles before ack on a ROM read; range 0..7.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_write  in  DATA_W  CPU write data
- data_read  out  DATA_W  CPU read data
- addr  in  ADDR_W  CPU byte address
- uds  in  1  upper strobe, active-high, data[15:8], even byte
- lds  in  1  lower strobe, active-high, data[7:0], odd byte
- rw  in  1  1=read, 0=write
- ack  out  1  cycle acknowledge
- mem_data_write  out  DATA_W  to memory
- mem_data_read  in  DATA_W  from memory
- mem_addr  out  ADDR_W  to memory
- mem_uds  out  1  to memory
- mem_lds  out  1  to memory
- mem_rw  out  1  to memory
- mem_ack  in  1  from memory
- rom_we  in  1  boot ROM write strobe (loader/debug port)
- rom_waddr  in  log2(BOOT_WORDS)  boot ROM word index
- rom_wdata  in  DATA_W  boot ROM write data
- boot_req  in  1  one-cycle pulse: re-enter boot mode
- bootmode  out  1  1 while overlay active

Behaviour:
- Reset: bootmode=1, mode FSM=BOOT, bus FSM=IDLE, ack=0, data_read=0, mem_uds=mem_lds=0, mem_rw=1. ROM contents are not reset; they are loaded only via rom_we.
- Cycle start: (uds|lds) rising from both-low, sampled at a clk edge.
- rom_hit = bootmode & rw & (addr < WINDOW_BYTES). ROM word index = addr[log2(BOOT_WORDS):1]; it aliases within the window.
- Bus FSM IDLE -> ROM_WAIT on a cycle start with rom_hit; otherwise IDLE -> MEM on a cycle start.
- ROM_WAIT: counter loads ROM_WAIT. It decrements each cycle; at 0 -> ROM_ACK.
  - data_read is registered ROM data, both lanes, regardless of strobes.
  - ROM_WAIT=0 gives ack in the 2nd cycle after the start edge.
- ROM_ACK: ack=1; hold until uds=lds=0 -> IDLE, ack=0 the same edge.
- MEM: mem_* mirror the CPU signals combinationally; ack = mem_ack; data_read = mem_data_read. Exit on strobes low -> IDLE.
- Outside MEM, mem_uds=mem_lds=0. Memory never sees ROM-hit reads.
- Writes always go to MEM, including in boot mode and inside the window.
- Mode FSM:
  - BOOT -> ARMED on a write cycle start with addr==EXIT_ADDR, uds&lds, data_write==EXIT_MAGIC.
  - ARMED -> RUN on the first strobe negation (uds,lds: 11 -> 00 between consecutive edges); bootmode=0 from the next cycle.
  - The magic write itself completes normally through MEM.
  - Byte-lane or wrong-data writes to EXIT_ADDR do not arm.
  - RUN -> BOOT on boot_req. If a bus cycle is in progress, take effect when the bus FSM returns to IDLE. A cycle never switches source mid-flight.
- rom_hit is evaluated only at cycle start.
- rom_we: writes rom_wdata into rom_waddr at the edge.
  - rom_we during ROM_WAIT to the index being read: the read returns the old word.
  - New data is visible to the next cycle.
- reset mid-cycle: all FSMs return to reset state immediately; ack drops the same edge.
- Simultaneous boot_req with arm/exit in BOOT/ARMED: boot_req wins; return to BOOT, disarm.

Test Plan:
- Load ROM words 0..4 = 0000,2000,0000,0008,4EFA; reset; reads at addr 0x000006 with uds=lds=1 -> data_read=0008, ack 2 cycles after start (ROM_WAIT=1), mem_uds/lds stay 0.
- In boot mode, read 0x001000 -> forwarded to memory, data_read=mem_data_read, ack follows mem_ack delayed 3 cycles; write 0x0055 to 0x000004 -> memory write issued.
- Write A9A9 to 0x000000 uds=lds=1 -> memory write occurs; bootmode stays 1 until strobes drop, then 0. Next read at 0x000006 returns memory data.
- Write A9A9 with only uds, and write A9A8 with both strobes -> bootmode remains 1.
- In RUN, pulse boot_req during a memory read -> cycle completes from memory; bootmode=1 after IDLE; next read at 0 returns ROM word 0.
- Assert reset while in ROM_ACK -> ack=0 next edge, bootmode=1; ROM contents preserved on a following read.
